// File: rtl/oledbw_pkg.sv
// Shared types for the OLED power sequencer: script entry codes, FSM states,
// entry width and the shutdown script base index.
package oledbw_pkg;

  localparam int         ENTRY_W   = 36;
  localparam logic [4:0] SHUT_BASE = 5'd16;

  typedef enum logic [1:0] {
    TY_WR  = 2'd0,
    TY_DLY = 2'd1,
    TY_RSV = 2'd2,
    TY_END = 2'd3
  } entry_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_ACKWAIT,
    ST_GUARD,
    ST_IDLEWAIT,
    ST_DELAY
  } state_e;

  function automatic logic [ENTRY_W-1:0] mk_entry(entry_type_e ty, logic [1:0] addr,
                                                  logic [31:0] data);
    return {ty, addr, data};
  endfunction

endpackage

// File: rtl/oledbw_seqrom.sv
// Script ROM for the OLED power sequencer, one-cycle registered read.
// The shutdown script at SHUT_BASE exists only with OLEDSEQ_SHUTDOWN_EN.
module oledbw_seqrom
  import oledbw_pkg::*;
(
  input  logic               i_clk,
  input  logic [4:0]         i_idx,
  output logic [ENTRY_W-1:0] o_entry
);

  logic [ENTRY_W-1:0] rom_d;

  always_comb begin
    rom_d = mk_entry(TY_END, 2'd0, 32'd0);
    case (i_idx)
      5'd0:  rom_d = mk_entry(TY_WR,  2'd3, 32'h0007_0001);
      5'd1:  rom_d = mk_entry(TY_DLY, 2'd0, 32'd1);
      5'd2:  rom_d = mk_entry(TY_WR,  2'd3, 32'h0004_0004);
      5'd3:  rom_d = mk_entry(TY_DLY, 2'd0, 32'd1);
      5'd4:  rom_d = mk_entry(TY_WR,  2'd0, 32'h0000_00AE);
      5'd5:  rom_d = mk_entry(TY_WR,  2'd0, 32'h0001_8D14);
      5'd6:  rom_d = mk_entry(TY_WR,  2'd0, 32'h0001_D9F1);
      5'd7:  rom_d = mk_entry(TY_WR,  2'd3, 32'h0002_0002);
      5'd8:  rom_d = mk_entry(TY_DLY, 2'd0, 32'd100);
      5'd9:  rom_d = mk_entry(TY_WR,  2'd0, 32'h0000_00AF);
`ifdef OLEDSEQ_SHUTDOWN_EN
      5'd16: rom_d = mk_entry(TY_WR,  2'd0, 32'h0000_00AE);
      5'd17: rom_d = mk_entry(TY_WR,  2'd3, 32'h0002_0000);
      5'd18: rom_d = mk_entry(TY_DLY, 2'd0, 32'd100);
      5'd19: rom_d = mk_entry(TY_WR,  2'd3, 32'h0001_0000);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    o_entry <= rom_d;
  end

endmodule

// File: rtl/oledbw_pwrseq.sv
// OLED power-up/shutdown sequencer: Wishbone master replaying a script ROM.
// Shutdown script and pending-shutdown flag require OLEDSEQ_SHUTDOWN_EN.
//
// state       | meaning
// IDLE        | port released to CPU, waiting for start/shutdown
// FETCH       | ROM entry valid, latch addr/data and branch on type
// ISSUE       | single-cycle strobe
// ACKWAIT     | waiting for controller ack (no timeout)
// GUARD       | GUARD cycles before i_int is trusted
// IDLEWAIT    | waiting for controller idle
// DELAY       | counting units x DLY_UNIT cycles
module oledbw_pwrseq
  import oledbw_pkg::*;
#(
  parameter int DLY_UNIT = 100000,
  parameter int DLY_BITS = 8,
  parameter int GUARD    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_shutdown,
  output logic        o_stb,
  output logic        o_we,
  output logic [1:0]  o_addr,
  output logic [31:0] o_data,
  input  logic        i_ack,
  input  logic        i_int,
  output logic        o_busy,
  output logic        o_ready
);

  localparam int TICK_W = (DLY_UNIT > 1) ? $clog2(DLY_UNIT) : 1;
  localparam int GRD_W  = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DLY_UNIT - 1);
  localparam logic [GRD_W-1:0]  GRD_LAST  = GRD_W'(GUARD - 1);

  state_e              state_q, state_d;
  logic [4:0]          pc_q, pc_d;
  logic [1:0]          addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                ready_q, ready_d;
  logic [GRD_W-1:0]    gcnt_q, gcnt_d;
  logic [DLY_BITS-1:0] units_q, units_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                pend_q, pend_d;

  logic [ENTRY_W-1:0]  rom_entry;
  entry_type_e         rom_type;
  logic [1:0]          rom_addr;
  logic [31:0]         rom_data;

  // ROM is addressed with next-pc so the entry is ready during FETCH.
  oledbw_seqrom u_rom (
    .i_clk   (i_clk),
    .i_idx   (pc_d),
    .o_entry (rom_entry)
  );

  assign rom_type = entry_type_e'(rom_entry[35:34]);
  assign rom_addr = rom_entry[33:32];
  assign rom_data = rom_entry[31:0];

`ifdef OLEDSEQ_SHUTDOWN_EN
  logic shut_go;
  assign shut_go = ready_q && (i_shutdown || pend_q);
`else
  logic unused_shutdown;
  assign unused_shutdown = i_shutdown;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = ready_q;
    gcnt_d  = gcnt_q;
    units_d = units_q;
    tick_d  = tick_q;
    pend_d  = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !ready_q) begin
          state_d = ST_FETCH;
          pc_d    = 5'd0;
        end
`ifdef OLEDSEQ_SHUTDOWN_EN
        else if (shut_go) begin
          state_d = ST_FETCH;
          pc_d    = SHUT_BASE;
          pend_d  = 1'b0;
        end
`endif
      end
      ST_FETCH: begin
        addr_d = rom_addr;
        data_d = rom_data;
        case (rom_type)
          TY_WR: state_d = ST_ISSUE;
          TY_DLY: begin
            if (rom_data[DLY_BITS-1:0] == '0) begin
              pc_d = pc_q + 5'd1;
            end else begin
              state_d = ST_DELAY;
              units_d = rom_data[DLY_BITS-1:0];
              tick_d  = TICK_LAST;
            end
          end
          default: begin
            state_d = ST_IDLE;
`ifdef OLEDSEQ_SHUTDOWN_EN
            ready_d = !ready_q;
`else
            ready_d = 1'b1;
`endif
          end
        endcase
      end
      ST_ISSUE: begin
        if (i_ack) begin
          state_d = ST_GUARD;
          gcnt_d  = GRD_LAST;
        end else begin
          state_d = ST_ACKWAIT;
        end
      end
      ST_ACKWAIT: begin
        if (i_ack) begin
          state_d = ST_GUARD;
          gcnt_d  = GRD_LAST;
        end
      end
      ST_GUARD: begin
        if (gcnt_q == '0) state_d = ST_IDLEWAIT;
        else              gcnt_d  = gcnt_q - GRD_W'(1);
      end
      ST_IDLEWAIT: begin
        if (i_int) begin
          state_d = ST_FETCH;
          pc_d    = pc_q + 5'd1;
        end
      end
      ST_DELAY: begin
        if (tick_q == '0) begin
          if (units_q == DLY_BITS'(1)) begin
            state_d = ST_FETCH;
            pc_d    = pc_q + 5'd1;
          end else begin
            units_d = units_q - DLY_BITS'(1);
            tick_d  = TICK_LAST;
          end
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef OLEDSEQ_SHUTDOWN_EN
    // Shutdown requested while powering up is replayed right after END.
    if (i_shutdown && state_q != ST_IDLE && !ready_q) pend_d = 1'b1;
`else
    pend_d = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      gcnt_q  <= '0;
      units_q <= '0;
      tick_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      gcnt_q  <= gcnt_d;
      units_q <= units_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
    end
  end

  assign o_stb   = (state_q == ST_ISSUE);
  assign o_we    = (state_q == ST_ISSUE);
  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_ready = ready_q;

endmodule

// File: tb/tb_oledbw_pwrseq.sv
// Randomized bench for oledbw_pwrseq against a script-level reference model
// and a behavioural controller model (ack latency, idle interrupt busy time).
module tb_oledbw_pwrseq;

  localparam int DLY_UNIT = 10;
  localparam int GUARD    = 2;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_shutdown, i_ack, i_int;
  logic        o_stb, o_we, o_busy, o_ready;
  logic [1:0]  o_addr;
  logic [31:0] o_data;

  always #5 clk = ~clk;

  oledbw_pwrseq #(.DLY_UNIT(DLY_UNIT), .DLY_BITS(8), .GUARD(GUARD)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_shutdown (i_shutdown),
    .o_stb      (o_stb),
    .o_we       (o_we),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .i_ack      (i_ack),
    .i_int      (i_int),
    .o_busy     (o_busy),
    .o_ready    (o_ready)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          units;
    bit          first;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, n_wr = 0, exp_total = 0, start_cyc = 0, last_stb_cyc = 0;
  int   pend_units = 0;
  bit   first_next = 0, saw_ready = 0, prev_stb = 0, mon_stb = 0;
  logic [1:0] mon_addr = 2'd0;

  int ack_lat = 1, busy0 = 0, bmax = 4;
  int ack_cnt = 0, int_cnt = 0, cur_lat = 1, cur_busy = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Script-level reference: writes in order, delay units accumulated before each write.
  task automatic add_step(input int ty, input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    if (ty == 1) begin
      pend_units += int'(d);
    end else begin
      e.addr  = a;
      e.data  = d;
      e.units = pend_units;
      e.first = first_next;
      exp_q.push_back(e);
      exp_total++;
      pend_units = 0;
      first_next = 0;
    end
  endtask

  task automatic load_powerup();
    pend_units = 0;
    add_step(0, 2'd3, 32'h0007_0001);
    add_step(1, 2'd0, 32'd1);
    add_step(0, 2'd3, 32'h0004_0004);
    add_step(1, 2'd0, 32'd1);
    add_step(0, 2'd0, 32'h0000_00AE);
    add_step(0, 2'd0, 32'h0001_8D14);
    add_step(0, 2'd0, 32'h0001_D9F1);
    add_step(0, 2'd3, 32'h0002_0002);
    add_step(1, 2'd0, 32'd100);
    add_step(0, 2'd0, 32'h0000_00AF);
  endtask

  task automatic load_shutdown();
    pend_units = 0;
    add_step(0, 2'd0, 32'h0000_00AE);
    add_step(0, 2'd3, 32'h0002_0000);
    add_step(1, 2'd0, 32'd100);
    add_step(0, 2'd3, 32'h0001_0000);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller model: ack after ack_lat cycles, i_int low through ack and busy time.
  initial begin
    i_ack = 1'b0;
    i_int = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mon_stb) begin
        cur_lat  = ack_lat;
        cur_busy = (mon_addr == 2'd0) ? busy0 : int'($urandom_range(0, bmax));
        ack_cnt  = ack_lat;
        int_cnt  = ack_lat + cur_busy;
      end
      i_ack = (ack_cnt == 1);
      if (ack_cnt > 0) ack_cnt--;
      i_int = (int_cnt == 0);
      if (int_cnt > 0) int_cnt--;
    end
  end

  // Bus monitor against the reference queue.
  initial begin
    exp_t e;
    int   gap, lo, hi;
    forever begin
      @(negedge clk);
      if (o_stb) begin
        chk("stb_we", o_we, 1);
        chk("stb_int_idle", i_int, 1);
        chk("stb_single", prev_stb, 0);
        chk("stb_ack_pending", ack_cnt != 0, 0);
        if (exp_q.size() == 0) begin
          chk("extra_wr", n_wr + 1, exp_total);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", o_addr, e.addr);
          chk("wr_data", o_data, e.data);
          if (e.first) begin
            chk("start_lat", cyc - start_cyc, 2);
          end else begin
            gap = cyc - last_stb_cyc;
            lo  = e.units * DLY_UNIT + cur_lat + GUARD;
            hi  = lo + cur_busy + 10;
            chk("gap_min", gap >= lo, 1);
            chk("gap_max", gap <= hi, 1);
          end
        end
        n_wr++;
        last_stb_cyc = cyc;
      end
      if (o_ready) saw_ready = 1;
      prev_stb = o_stb;
      mon_stb  = o_stb;
      mon_addr = o_addr;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    exp_total -= exp_q.size();
    exp_q.delete();
  endtask

  task automatic pulse_start(input bit rec);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    if (rec) start_cyc = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic pulse_shut(input bit rec);
    @(posedge clk);
    #1;
    i_shutdown = 1'b1;
    if (rec) start_cyc = cyc;
    @(posedge clk);
    #1;
    i_shutdown = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (exp_q.size() == 0 && !o_busy) break;
      @(posedge clk);
      #1;
    end
    chk(tag, exp_q.size() == 0 && !o_busy, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_shutdown = 1'b0;
    do_reset();
    chk("rst_stb", o_stb, 0);
    chk("rst_we", o_we, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 0);

    pulse_shut(0);
    idle_cycles(20);
    chk("shut_unpowered_busy", o_busy, 0);
    chk("shut_unpowered_wr", n_wr, exp_total);

    // Power-up, fast ack, addr-0 writes hold i_int low for 50 cycles.
    ack_lat = 1; busy0 = 50; bmax = 4;
    first_next = 1;
    load_powerup();
    pulse_start(1);
    idle_cycles(30);
    chk("busy_mid_powerup", o_busy, 1);
    pulse_start(0);
    wait_done("runA_done", 5000);
    chk("runA_ready", o_ready, 1);
    chk("runA_wr", n_wr, exp_total);

    pulse_start(0);
    idle_cycles(30);
    chk("start_ready_busy", o_busy, 0);
    chk("start_ready_wr", n_wr, exp_total);

`ifdef OLEDSEQ_SHUTDOWN_EN
    first_next = 1;
    load_shutdown();
    pulse_shut(1);
    wait_done("shut_done", 5000);
    chk("shut_ready", o_ready, 0);
    chk("shut_wr", n_wr, exp_total);
`else
    pulse_shut(0);
    idle_cycles(30);
    chk("shut_ignored_busy", o_busy, 0);
    chk("shut_ignored_ready", o_ready, 1);
    chk("shut_ignored_wr", n_wr, exp_total);
`endif

    // Slow ack, random busy; shutdown requested mid power-up when enabled.
    do_reset();
    chk("runB_rst_ready", o_ready, 0);
    saw_ready = 0;
    ack_lat = 5; busy0 = int'($urandom_range(0, 20)); bmax = 6;
    first_next = 1;
    load_powerup();
`ifdef OLEDSEQ_SHUTDOWN_EN
    load_shutdown();
`endif
    pulse_start(1);
    idle_cycles(25);
`ifdef OLEDSEQ_SHUTDOWN_EN
    pulse_shut(0);
`endif
    wait_done("runB_done", 8000);
`ifdef OLEDSEQ_SHUTDOWN_EN
    chk("runB_ready_pulse", saw_ready, 1);
    chk("runB_ready_final", o_ready, 0);
`else
    chk("runB_ready", o_ready, 1);
`endif
    chk("runB_wr", n_wr, exp_total);

    // Reset while counting the long delay aborts the script.
    do_reset();
    ack_lat = int'($urandom_range(1, 3)); busy0 = int'($urandom_range(0, 10)); bmax = 4;
    base = n_wr;
    first_next = 1;
    load_powerup();
    pulse_start(1);
    for (int k = 0; k < 3000; k++) begin
      if (n_wr - base >= 6) break;
      @(posedge clk);
      #1;
    end
    chk("runC_reach_delay", n_wr - base, 6);
    idle_cycles(100);
    chk("runC_in_delay", o_busy, 1);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    chk("runC_rst_busy", o_busy, 0);
    chk("runC_rst_ready", o_ready, 0);
    exp_total -= exp_q.size();
    exp_q.delete();
    idle_cycles(2000);
    chk("runC_no_wr", n_wr, exp_total);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
